// File: rtl/calc_pkg.sv
// Shared calculator definitions.
// Holds the operator key codes that follow the digits 0-9 on the keypad,
// the keypad scanner state encoding and two small helpers that decode a
// sampled row vector. The row vector is active-low.
package calc_pkg;

  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_SUB   = 4'hB;
  localparam logic [3:0] KEY_STORE = 4'hC;
  localparam logic [3:0] KEY_LOAD  = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_NOP   = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  // True when exactly one row line is pulled low.
  function automatic logic is_one_low(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  // Index of the low row. Only meaningful when is_one_low() holds.
  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key delivery channel from the keypad scanner to the calculator control FSM.
//   tecla    : code of the last accepted key (4*row + col)
//   ready    : one-cycle strobe in the cycle tecla first shows a new code
//   key_held : high while the accepted key is still down
// master = scanner side, slave = control FSM side.
interface keypad_scanner_if;
  logic [3:0] tecla;
  logic       ready;
  logic       key_held;

  modport master (output tecla, output ready, output key_held);
  modport slave  (input  tecla, input  ready, input  key_held);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
//   clk   : destination clock
//   reset : synchronous, active-high; loads RST_VAL into both stages
//   d     : asynchronous input bus
//   q     : synchronized output bus
module sync_2ff #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press and release debounce.
//   clk     : system clock
//   reset   : synchronous, active-high
//   row_in  : keypad rows, active-low, asynchronous to clk
//   col_out : column drive, active-low, exactly one bit low
//   kp      : key delivery channel (tecla / ready / key_held)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | walk the columns one per tick looking for a single low row
// DEBOUNCE | column frozen, count ticks where the captured row stays low
// HELD     | key accepted, count ticks of all-rows-high to accept release
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  keypad_scanner_if.master kp
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rs;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  scan_state_e   state_q;
  logic [1:0]    col_q;
  logic [3:0]    col_out_q;
  logic [1:0]    row_q;
  logic [DW-1:0] dbc_q;
  logic [3:0]    tecla_q;
  logic          ready_q;
  logic          held_q;
  logic [3:0]    row_pat;

  sync_2ff #(.W(4), .RST_VAL(4'b1111)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (rs)
  );

  always_ff @(posedge clk) begin
    if (reset)     tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  // Row pattern the captured key produces on its own column.
  assign row_pat = ~(4'b0001 << row_q);

  // col_q and col_out_q always advance together; col_out_q is kept as its
  // own register so the pin drive comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      col_out_q <= 4'b1110;
      row_q     <= 2'd0;
      dbc_q     <= '0;
      tecla_q   <= 4'd0;
      ready_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (is_one_low(rs)) begin
              row_q   <= low_index(rs);
              dbc_q   <= '0;
              state_q <= DEBOUNCE;
            end else begin
              col_q     <= col_q + 2'd1;
              col_out_q <= {col_out_q[2:0], col_out_q[3]};
            end
          end
          DEBOUNCE: begin
            if (rs == row_pat) begin
              if (dbc_q == DB_LAST) begin
                tecla_q <= {row_q, col_q};
                ready_q <= 1'b1;
                held_q  <= 1'b1;
                dbc_q   <= '0;
                state_q <= HELD;
              end else begin
                dbc_q <= dbc_q + 1'b1;
              end
            end else begin
              col_q     <= col_q + 2'd1;
              col_out_q <= {col_out_q[2:0], col_out_q[3]};
              state_q   <= SCAN;
            end
          end
          HELD: begin
            // Any low row, including a different key, restarts the release count.
            if (rs == 4'b1111) begin
              if (dbc_q == DB_LAST) begin
                held_q    <= 1'b0;
                dbc_q     <= '0;
                col_q     <= col_q + 2'd1;
                col_out_q <= {col_out_q[2:0], col_out_q[3]};
                state_q   <= SCAN;
              end else begin
                dbc_q <= dbc_q + 1'b1;
              end
            end else begin
              dbc_q <= '0;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign col_out     = col_out_q;
  assign kp.tecla    = tecla_q;
  assign kp.ready    = ready_q;
  assign kp.key_held = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] pressed;

  int vectors    = 0;
  int miscompares = 0;
  int cyc_n      = 0;
  int base       = 0;
  int ready_cnt  = 0;
  int ready_dbl  = 0;
  logic ready_prev = 1'b0;
  int n;

  keypad_scanner_if kp_if ();

  keypad_scanner #(.CLK_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .row_in  (row_in),
    .col_out (col_out),
    .kp      (kp_if)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key at (r,c) pulls row r low while column c is driven.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && (col_out[c] == 1'b0)) row_in[r] = 1'b0;
  end

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (kp_if.ready === 1'b1) ready_cnt <= ready_cnt + 1;
    if (kp_if.ready === 1'b1 && ready_prev === 1'b1) ready_dbl <= ready_dbl + 1;
    ready_prev <= kp_if.ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int k);
    while ((cyc_n - base) < k) @(negedge clk);
  endtask

  task automatic wait_ready(input int max, output int waited);
    waited = 0;
    while (waited < max) begin
      @(negedge clk);
      waited++;
      if (kp_if.ready === 1'b1) break;
    end
  endtask

  initial begin
    pressed = 16'h0000;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    base  = cyc_n;
    reset = 1'b0;

    // 1. reset values and column rotation
    chk("rst_col", col_out, 4'b1110);
    chk("rst_tecla", kp_if.tecla, 4'h0);
    chk("rst_ready", kp_if.ready, 1'b0);
    chk("rst_held", kp_if.key_held, 1'b0);
    at(4);  chk("rot_c1", col_out, 4'b1101);
    at(8);  chk("rot_c2", col_out, 4'b1011);
    at(12); chk("rot_c3", col_out, 4'b0111);
    at(16); chk("rot_wrap", col_out, 4'b1110);

    // 2. clean press of row 2 col 1
    pressed = 16'h0001 << 9;
    wait_ready(60, n);
    chk("press_latency", n, 20);
    chk("press_tecla", kp_if.tecla, 4'h9);
    chk("press_held", kp_if.key_held, 1'b1);
    chk("press_col_frozen", col_out, 4'b1101);
    at(37);
    chk("ready_one_cycle", kp_if.ready, 1'b0);
    at(116);
    chk("held_before_rel", kp_if.key_held, 1'b1);
    pressed = 16'h0000;
    at(127); chk("held_rel_tick2", kp_if.key_held, 1'b1);
    at(128);
    chk("rel_accepted", kp_if.key_held, 1'b0);
    chk("rel_col_adv", col_out, 4'b1011);
    chk("rel_tecla_kept", kp_if.tecla, 4'h9);
    chk("rel_ready_cnt", ready_cnt, 1);

    // 3. bounce on row 0 col 2
    pressed = 16'h0001 << 2;
    at(132);
    chk("bounce_col_frozen", col_out, 4'b1011);
    pressed = 16'h0000;
    at(136);
    chk("bounce_col_next", col_out, 4'b0111);
    chk("bounce_tecla", kp_if.tecla, 4'h9);
    chk("bounce_ready_cnt", ready_cnt, 1);

    // 4. two rows low on col 0, then row 3 col 2
    pressed = (16'h0001 << 0) | (16'h0001 << 4);
    at(144);
    chk("ambig_col_adv", col_out, 4'b1101);
    chk("ambig_ready_cnt", ready_cnt, 1);
    pressed = 16'h0001 << 14;
    wait_ready(60, n);
    chk("enter_latency", n, 20);
    chk("enter_tecla", kp_if.tecla, KEY_ENTER);

    // 5. second key while held, release, then row 2 col 2
    at(170);
    pressed = (16'h0001 << 14) | (16'h0001 << 2);
    at(180);
    pressed = 16'h0001 << 2;
    at(190);
    chk("second_held", kp_if.key_held, 1'b1);
    chk("second_ready_cnt", ready_cnt, 2);
    chk("second_tecla", kp_if.tecla, KEY_ENTER);
    pressed = 16'h0000;
    at(203); chk("both_rel_pending", kp_if.key_held, 1'b1);
    at(204);
    chk("both_rel_done", kp_if.key_held, 1'b0);
    chk("both_rel_col", col_out, 4'b0111);
    pressed = 16'h0001 << 10;
    wait_ready(80, n);
    chk("add_latency", n, 28);
    chk("add_tecla", kp_if.tecla, KEY_ADD);
    at(240);
    pressed = 16'h0000;
    at(252);
    chk("add_rel", kp_if.key_held, 1'b0);
    chk("add_ready_cnt", ready_cnt, 3);

    // 6. reset at debounce count 2 for row 1 col 0
    pressed = 16'h0001 << 4;
    at(268);
    reset   = 1'b1;
    pressed = 16'h0000;
    at(269);
    chk("abort_col", col_out, 4'b1110);
    chk("abort_tecla", kp_if.tecla, 4'h0);
    chk("abort_ready", kp_if.ready, 1'b0);
    chk("abort_held", kp_if.key_held, 1'b0);
    at(270);
    reset = 1'b0;
    at(300);
    chk("abort_no_ready", ready_cnt, 3);
    chk("abort_tecla_idle", kp_if.tecla, 4'h0);
    chk("ready_never_double", ready_dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans the calculator's 4x4 matrix keypad, debounces presses and releases, and delivers one 4-bit key code per physical press to the calculator control FSM. The code is delivered on tecla, accompanied by a single-cycle ready strobe. The block sits directly upstream of the control FSM: digits 0-9, then add, subtract, store, load, enter and no-op as codes 10-15. There is no auto-repeat; a key must be released before another press is accepted.

Parameters:
CLK_DIV, 1000, clock cycles per scan tick; must be >=2. Also serves as the column settle time.
DEBOUNCE_CNT, 8, consecutive matching scan ticks required to accept a press or a release; must be >=1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col_out  out  4  keypad column drive, active-low, exactly one bit low at all times
tecla  out  4  code of last accepted key, = 4*row + col; held until the next accepted press
ready  out  1  one-cycle pulse, asserted in the cycle tecla first shows the new code
key_held  out  1  high from acceptance of a press until its release is accepted

Behaviour:
- Reset (reset=1 at a clk edge): effective at that edge.
  - Outputs: col_out=4'b1110 (column 0 driven), tecla=0, ready=0, key_held=0.
  - Internals: state=SCAN, tick counter=0, debounce counter=0, synchronizer flops=4'b1111.
  - Reset mid-debounce or mid-hold aborts; no ready is produced.
- row_in passes through a 2-flop synchronizer; all decisions use the synchronized value rs.
- Tick: free-running counter 0..CLK_DIV-1; tick=1 in the cycle the counter equals CLK_DIV-1.
- States:
  - SCAN: on tick, examine rs for the current column c.
    - Exactly one bit low (row r) -> capture r,c; debounce count=0; go DEBOUNCE; column frozen.
    - Otherwise (no bit low, or 2+ bits low, which is ambiguous) -> advance the column c->(c+1) mod 4 (3 wraps to 0) and stay in SCAN.
  - DEBOUNCE: column frozen. On each tick:
    - rs equals the captured single-low pattern -> count+1.
    - Any other rs value -> go SCAN and advance the column.
    - When count reaches DEBOUNCE_CNT -> next cycle: tecla<=4*r+c, ready=1 for exactly one cycle, key_held=1; go HELD.
  - HELD: column frozen. On tick:
    - rs==4'b1111 -> release count+1.
    - Else -> release count=0. Other keys pressed meanwhile are ignored.
    - Release count reaches DEBOUNCE_CNT -> key_held=0, advance the column, go SCAN.
- Latency: the press is detected on tick T0. ready asserts the cycle after tick T(DEBOUNCE_CNT), i.e. DEBOUNCE_CNT*CLK_DIV+1 cycles after T0, plus 2 synchronizer cycles relative to the pin.
- Column change happens only on a tick edge. The next sample comes CLK_DIV cycles later, which gives the settle time.
- ready never asserts on two consecutive cycles. At most one ready per press/release cycle.
- tecla is unchanged by release, by a rejected bounce and by reset-free idle.

Decomposition:
- Shared package calc_pkg holds:
  - Key codes: KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_STORE=4'hC, KEY_LOAD=4'hD, KEY_ENTER=4'hE, KEY_NOP=4'hF.
  - The scanner state encoding (SCAN, DEBOUNCE, HELD).
- Sub-module sync_2ff, a 4-bit two-flop synchronizer with reset value parameter, instantiated for row_in.

Test Plan:
All scenarios use CLK_DIV=4, DEBOUNCE_CNT=3.
1. Reset: assert reset 2 cycles, rows=4'b1111 -> col_out=4'b1110, tecla=0, ready=0, key_held=0; col_out rotates 1110->1101->1011->0111->1110 every 4 cycles.
2. Clean press of row 2 col 1 (row_in=4'b1011 only while col_out=4'b1101), held 100 cycles -> exactly one ready pulse with tecla=4'h9. key_held=1 until release plus 3 ticks, then scanning resumes.
3. Bounce: row 0 col 2 low for 1 tick then high -> no ready, tecla unchanged, scan resumes from column 3.
4. Two rows low on the same column (row_in=4'b1100 on col 0) -> ignored, no ready. Press of row 3 col 2 (KEY_ENTER) afterwards -> ready with tecla=4'hE.
5. Second key pressed while first is held -> no second ready. After both are released and the release is accepted, a new press of row 2 col 2 -> ready with tecla=4'hA.
6. Reset asserted at count 2 of DEBOUNCE -> no ready, all outputs at reset values the next cycle.
